// File: rtl/des_pkg.sv
// Shared constants, permutation tables and state type for the DES key-schedule generator.
// Tables use DES 1-based bit numbering: bit 1 is the MSB of the vector being permuted.
package des_pkg;

   localparam int unsigned KEY_W    = 64;
   localparam int unsigned HALF_W   = 28;
   localparam int unsigned SUBKEY_W = 48;
   localparam int unsigned ROUNDS   = 16;

   localparam int unsigned PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef enum logic {StIdle, StRun} state_e;

   // Rotate one 28-bit half by 1 or 2 positions, left or right.
   function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                  input logic two, input logic right);
      logic [HALF_W-1:0] r;
      if (right) r = two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
      else       r = two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
      return r;
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit {C,D} in, 48-bit subkey out.
module des_pc2
   import des_pkg::*;
(
   input  logic [2*HALF_W-1:0] cd_i,
   output logic [SUBKEY_W-1:0] k_o
);

   for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
      assign k_o[SUBKEY_W-1-i] = cd_i[2*HALF_W-PC2[i]];
   end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: one registered subkey per accepted valid/ready beat.
// Optional DES_KEY_DECRYPT_EN adds a 'dec' input that emits K16..K1 instead.
module des_key_sched
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_W-1:0]    key,
   input  logic                start,
`ifdef DES_KEY_DECRYPT_EN
   input  logic                dec,
`endif
   output logic                ready,
   output logic [SUBKEY_W-1:0] k,
   output logic                k_valid,
   input  logic                k_ready,
   output logic [3:0]          k_idx,
   output logic                done
);

   state_e              state_q, state_d;
   logic [HALF_W-1:0]   c_q, c_d, d_q, d_d, c0, d0;
   logic [SUBKEY_W-1:0] k_q, k_next;
   logic [3:0]          idx_q, idx_d, idx_nx;
   logic                valid_q, valid_d, done_q, done_d, dec_q, dec_d, dec_in;
   logic [2*HALF_W-1:0] pc1_out;
   logic                unused_parity;

   for (genvar i = 0; i < 2*HALF_W; i++) begin : g_pc1
      assign pc1_out[2*HALF_W-1-i] = key[KEY_W-PC1[i]];
   end
   assign {c0, d0} = pc1_out;
   assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

`ifdef DES_KEY_DECRYPT_EN
   assign dec_in = dec;
`else
   assign dec_in = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      dec_d   = dec_q;
      idx_nx  = idx_q + 4'd1;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               valid_d = 1'b1;
               idx_d   = 4'd0;
               dec_d   = dec_in;
               // Decrypt order starts at K16, whose C/D equal C0/D0.
               if (dec_in) begin
                  c_d = c0;
                  d_d = d0;
               end else begin
                  c_d = rot_half(c0, SHIFT[0] == 2, 1'b0);
                  d_d = rot_half(d0, SHIFT[0] == 2, 1'b0);
               end
            end
         end
         StRun: begin
            if (valid_q && k_ready) begin
               if (idx_q == 4'd15) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_nx;
                  if (dec_q) begin
                     c_d = rot_half(c_q, SHIFT[4'd15-idx_q] == 2, 1'b1);
                     d_d = rot_half(d_q, SHIFT[4'd15-idx_q] == 2, 1'b1);
                  end else begin
                     c_d = rot_half(c_q, SHIFT[idx_nx] == 2, 1'b0);
                     d_d = rot_half(d_q, SHIFT[idx_nx] == 2, 1'b0);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // PC-2 sees next-state C/D so the subkey register tracks C/D in the same cycle.
   des_pc2 u_pc2 (
      .cd_i ({c_d, d_d}),
      .k_o  (k_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         c_q     <= '0;
         d_q     <= '0;
         k_q     <= '0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         k_q     <= k_next;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         dec_q   <= dec_d;
      end
   end

   assign ready   = (state_q == StIdle);
   assign k       = k_q;
   assign k_valid = valid_q;
   assign k_idx   = idx_q;
   assign done    = done_q;

endmodule
